// File: rtl/telemetry_uart_tx.sv
// Telemetry packet transmitter: snapshots attitude and wheel speeds and sends them as one 8N1 UART frame.
// Optional macro TELEM_CHECKSUM_EN appends an XOR checksum byte (8 bytes instead of 7).
module telemetry_uart_tx #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int PERIOD_CYCLES = 10_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       send,
  input  logic [8:0] pitch,
  input  logic [8:0] yaw,
  input  logic [9:0] speed_left,
  input  logic [9:0] speed_right,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] dropped_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD_CYCLES - 1);
`ifdef TELEM_CHECKSUM_EN
  localparam int N_BYTES = 8;
`else
  localparam int N_BYTES = 7;
`endif
  localparam logic [2:0] LAST_BYTE = 3'(N_BYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [TW-1:0] timer_r;
  logic [1:0]    state_r;
  logic [CW-1:0] clk_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [2:0]    byte_idx_r;
  logic [7:0]    seq_r;
  logic [7:0]    snap_seq_r;
  logic [8:0]    snap_pitch_r;
  logic [8:0]    snap_yaw_r;
  logic [9:0]    snap_left_r;
  logic [9:0]    snap_right_r;
  logic          tx_r;
  logic          busy_r;
  logic          frame_done_r;
  logic [7:0]    dropped_r;

  logic       tick_s;
  logic       trigger_s;
  logic       accept_s;
  logic       reject_s;
  logic       bit_end_s;
  logic [7:0] ext_byte_s;
  logic [7:0] byte_s;

`ifdef TELEM_CHECKSUM_EN
  function automatic logic [7:0] xor_sum(input logic [7:0] b1, input logic [7:0] b2,
                                         input logic [7:0] b3, input logic [7:0] b4,
                                         input logic [7:0] b5, input logic [7:0] b6);
    return b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6;
  endfunction
`endif

  assign tick_s     = enable & (timer_r == TIMER_LAST);
  assign trigger_s  = tick_s | send;
  // The frame_done cycle still blocks a new frame even though busy has dropped.
  assign accept_s   = trigger_s & (state_r == IDLE) & ~frame_done_r;
  assign reject_s   = trigger_s & ~accept_s;
  assign bit_end_s  = (clk_cnt_r == CLK_LAST);
  assign ext_byte_s = {2'b00, snap_right_r[9:8], snap_left_r[9:8], snap_yaw_r[8], snap_pitch_r[8]};

  // Period timer: free-runs while enabled and wraps, clears when disabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_r <= {TW{1'b0}};
    end else if (!enable || (timer_r == TIMER_LAST)) begin
      timer_r <= {TW{1'b0}};
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Packet byte selected by the current byte index, built from the snapshot.
  always_comb begin
    byte_s = 8'h00;
    case (byte_idx_r)
      3'd0:    byte_s = 8'hA5;
      3'd1:    byte_s = snap_seq_r;
      3'd2:    byte_s = snap_pitch_r[7:0];
      3'd3:    byte_s = snap_yaw_r[7:0];
      3'd4:    byte_s = snap_left_r[7:0];
      3'd5:    byte_s = snap_right_r[7:0];
      3'd6:    byte_s = ext_byte_s;
`ifdef TELEM_CHECKSUM_EN
      3'd7:    byte_s = xor_sum(snap_seq_r, snap_pitch_r[7:0], snap_yaw_r[7:0],
                                snap_left_r[7:0], snap_right_r[7:0], ext_byte_s);
`endif
      default: byte_s = 8'h00;
    endcase
  end

  // Saturating count of triggers that arrive while a frame is in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      dropped_r <= 8'd0;
    end else if (reject_s && (dropped_r != 8'hFF)) begin
      dropped_r <= dropped_r + 8'd1;
    end else begin
      dropped_r <= dropped_r;
    end
  end

  // Frame sequencer: snapshot on trigger, then start/data/stop per byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      clk_cnt_r    <= {CW{1'b0}};
      bit_idx_r    <= 3'd0;
      byte_idx_r   <= 3'd0;
      seq_r        <= 8'd0;
      snap_seq_r   <= 8'd0;
      snap_pitch_r <= 9'd0;
      snap_yaw_r   <= 9'd0;
      snap_left_r  <= 10'd0;
      snap_right_r <= 10'd0;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            snap_seq_r   <= seq_r;
            snap_pitch_r <= pitch;
            snap_yaw_r   <= yaw;
            snap_left_r  <= speed_left;
            snap_right_r <= speed_right;
            seq_r        <= seq_r + 8'd1;
            busy_r       <= 1'b1;
            tx_r         <= 1'b0;
            clk_cnt_r    <= {CW{1'b0}};
            byte_idx_r   <= 3'd0;
            state_r      <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            clk_cnt_r <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            tx_r      <= byte_s[0];
            state_r   <= DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            clk_cnt_r <= {CW{1'b0}};
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= byte_s[bit_idx_r + 3'd1];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            clk_cnt_r <= {CW{1'b0}};
            if (byte_idx_r != LAST_BYTE) begin
              byte_idx_r <= byte_idx_r + 3'd1;
              tx_r       <= 1'b0;
              state_r    <= START;
            end else begin
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
              tx_r         <= 1'b1;
              state_r      <= IDLE;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx       = tx_r;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;
  assign dropped_count = dropped_r;

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// Bench for telemetry_uart_tx: trigger-level reference model feeds a frame scoreboard; a
// line monitor rebuilds each frame from uart_tx and checks timing and content against it.
module tb_telemetry_uart_tx;

  localparam int CPB = 4;
  localparam int PER = 1000;
`ifdef TELEM_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif
  localparam int FLEN = NB * 10 * CPB;

  typedef struct {
    int              start;
    logic [7:0][7:0] bytes;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       send = 1'b0;
  logic [8:0] pitch = 9'd0;
  logic [8:0] yaw = 9'd0;
  logic [9:0] speed_left = 10'd0;
  logic [9:0] speed_right = 10'd0;
  logic       uart_tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] dropped_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int     edge_n = 0;
  int     en_run = 0;
  int     next_ok = 0;
  int     m_seq = 0;
  int     m_drop = 0;
  frame_t expq[$];

  // monitor state
  bit         in_frame = 1'b0;
  bit         fd_follow = 1'b0;
  int         f_start = 0;
  int         busy_bad = 0;
  bit         trace[$];
  logic [7:0] last_bytes [0:7];
  int         seq_log[$];

  telemetry_uart_tx #(.CLKS_PER_BIT(CPB), .PERIOD_CYCLES(PER)) dut (
    .clock(clock), .reset(reset), .enable(enable), .send(send),
    .pitch(pitch), .yaw(yaw), .speed_left(speed_left), .speed_right(speed_right),
    .uart_tx(uart_tx), .busy(busy), .frame_done(frame_done), .dropped_count(dropped_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0][7:0] build(input int seq, input logic [8:0] p, input logic [8:0] y,
                                            input logic [9:0] sl, input logic [9:0] sr);
    logic [7:0][7:0] b;
    b    = '0;
    b[0] = 8'hA5;
    b[1] = seq[7:0];
    b[2] = p[7:0];
    b[3] = y[7:0];
    b[4] = sl[7:0];
    b[5] = sr[7:0];
    b[6] = {2'b00, sr[9:8], sl[9:8], y[8], p[8]};
    if (NB == 8) b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
    return b;
  endfunction

  // Reference model: decides at every edge whether a trigger starts a frame or is dropped.
  initial begin
    forever begin
      @(posedge clock);
      edge_n++;
      if (reset) begin
        m_seq = 0; m_drop = 0; en_run = 0; next_ok = edge_n + 1;
        expq.delete();
      end else begin
        bit tick;
        frame_t f;
        tick = 1'b0;
        if (enable) begin
          tick = ((en_run % PER) == PER - 1);
          en_run++;
        end else begin
          en_run = 0;
        end
        if (tick || send) begin
          if (edge_n >= next_ok) begin
            f.start = edge_n;
            f.bytes = build(m_seq, pitch, yaw, speed_left, speed_right);
            expq.push_back(f);
            m_seq = (m_seq + 1) % 256;
            next_ok = edge_n + FLEN + 2;
          end else begin
            m_drop = (m_drop == 255) ? 255 : m_drop + 1;
          end
        end
      end
    end
  end

  task automatic analyse();
    frame_t e;
    int bad;
    if (expq.size() == 0) begin
      check("unexpected_frame", 64'(expq.size()), 64'd1);
      return;
    end
    e = expq.pop_front();
    check("start_cycle", 64'(f_start), 64'(e.start));
    check("frame_len", 64'(edge_n - f_start), 64'(FLEN));
    check("busy_in_frame", 64'(busy_bad), 64'd0);
    check("busy_at_done", 64'(busy), 64'd0);
    bad = 0;
    for (int i = 0; i < NB * 10 * CPB; i++) begin
      int bp;
      bit v;
      bp = (i % 40) / CPB;
      v = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : e.bytes[i / 40][bp - 1];
      if (i >= trace.size() || trace[i] != v) bad++;
    end
    check("bit_waveform", 64'(bad), 64'd0);
    for (int i = 0; i < NB; i++) begin
      logic [7:0] d;
      d = 8'h00;
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = i * 40 + (1 + j) * CPB + CPB / 2;
        if (idx < trace.size()) d[j] = trace[idx];
      end
      last_bytes[i] = d;
      check($sformatf("byte%0d", i), 64'(d), 64'(e.bytes[i]));
    end
    seq_log.push_back(int'(last_bytes[1]));
  endtask

  // Line monitor: rebuilds frames from uart_tx at falling edges and scores them.
  initial begin
    forever begin
      @(negedge clock);
      if (fd_follow) begin
        check("frame_done_pulse", 64'(frame_done), 64'd0);
        fd_follow = 1'b0;
      end
      if (reset) begin
        in_frame = 1'b0;
        trace.delete();
      end else if (!in_frame) begin
        if (frame_done) begin
          check("stray_frame_done", 64'(frame_done), 64'd0);
        end else if (uart_tx === 1'b0) begin
          in_frame = 1'b1;
          f_start  = edge_n;
          trace.delete();
          trace.push_back(1'b0);
          busy_bad = (busy === 1'b1) ? 0 : 1;
        end
      end else if (frame_done) begin
        analyse();
        in_frame  = 1'b0;
        fd_follow = 1'b1;
      end else begin
        trace.push_back(uart_tx === 1'b1);
        if (busy !== 1'b1) busy_bad++;
        if (trace.size() > FLEN + 8) begin
          check("frame_timeout", 64'(trace.size()), 64'(FLEN));
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_send();
    send = 1'b1;
    step(1);
    send = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while ((busy || expq.size() != 0 || in_frame) && i < 4000) begin
      step(1);
      i++;
    end
    check({name, "_idle_wait"}, 64'(i < 4000), 64'd1);
    step(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int i;
    // reset values
    step(3);
    @(negedge clock);
    check("rst_uart_tx", 64'(uart_tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_dropped", 64'(dropped_count), 64'd0);
    step(1);
    reset = 1'b0;
    step(2);

    // basic frame against literal bytes
    pitch = 9'h1FD; yaw = 9'h05A; speed_left = 10'h155; speed_right = 10'h2AA;
    pulse_send();
    wait_idle("basic");
    check("basic_b0", 64'(last_bytes[0]), 64'h00A5);
    check("basic_b1", 64'(last_bytes[1]), 64'h0000);
    check("basic_b2", 64'(last_bytes[2]), 64'h00FD);
    check("basic_b3", 64'(last_bytes[3]), 64'h005A);
    check("basic_b4", 64'(last_bytes[4]), 64'h0055);
    check("basic_b5", 64'(last_bytes[5]), 64'h00AA);
    check("basic_b6", 64'(last_bytes[6]), 64'h0025);
`ifdef TELEM_CHECKSUM_EN
    check("basic_b7", 64'(last_bytes[7]), 64'h007D);
`endif

    // drops: mid-frame and in the frame_done cycle
    base = seq_log.size();
    pulse_send();
    step(49);
    pulse_send();
    i = 0;
    while (frame_done !== 1'b1 && i < 2000) begin
      @(negedge clock);
      i++;
    end
    check("drop_wait_done", 64'(i < 2000), 64'd1);
    send = 1'b1;
    @(posedge clock);
    #1;
    send = 1'b0;
    wait_idle("drop");
    check("drop_frames", 64'(seq_log.size() - base), 64'd1);
    check("drop_count", 64'(dropped_count), 64'd2);
    check("drop_model", 64'(dropped_count), 64'(m_drop));

    // snapshot coherence
    pitch = 9'h1FD;
    pulse_send();
    step(50);
    pitch = 9'h010;
    wait_idle("snap1");
    check("snap_old_pitch", 64'(last_bytes[2]), 64'h00FD);
    pulse_send();
    wait_idle("snap2");
    check("snap_new_pitch", 64'(last_bytes[2]), 64'h0010);

    // reset during b3 data bits
    pulse_send();
    step(130);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_uart_tx", 64'(uart_tx), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_dropped", 64'(dropped_count), 64'd0);
    step(2);
    pulse_send();
    wait_idle("midrst");
    check("midrst_seq", 64'(last_bytes[1]), 64'd0);

    // randomized traffic, some triggers land mid-frame
    for (int k = 0; k < 25; k++) begin
      pitch = 9'($urandom); yaw = 9'($urandom);
      speed_left = 10'($urandom); speed_right = 10'($urandom);
      pulse_send();
      step($urandom_range(1, 400));
    end
    wait_idle("random");
    check("random_dropped", 64'(dropped_count), 64'(m_drop));

    // periodic frames
    do_reset();
    base = seq_log.size();
    enable = 1'b1;
    step(3500);
    enable = 1'b0;
    wait_idle("periodic");
    check("periodic_frames", 64'(seq_log.size() - base), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (base + k < seq_log.size()) check($sformatf("periodic_seq%0d", k), 64'(seq_log[base + k]), 64'(k));
    end

    // saturation
    send = 1'b1;
    step(600);
    send = 1'b0;
    wait_idle("sat");
    check("sat_dropped", 64'(dropped_count), 64'd255);
    check("sat_model", 64'(dropped_count), 64'(m_drop));
    check("final_queue_empty", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/telemetry_uart_tx.md
Name: telemetry_uart_tx

Overview:
Outbound telemetry transmitter on the BLE UART link: carries robot state from the FPGA to the BLE module, the reverse of the command path. It periodically, or on demand, snapshots MPU pitch/yaw and the control-loop wheel speeds. Each snapshot is serialised as one framed packet on 8N1 UART, driving the BLE module's RX pin. It sits beside the bluetooth wrapper in the top level.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud)
PERIOD_CYCLES, 10_000_000, cycles between automatic frames (10 Hz)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  enables the periodic frame timer
send  in  1  single-cycle manual frame request
pitch  in  9  signed MPU pitch
yaw  in  9  signed MPU yaw
speed_left  in  10  signed target speed, left wheel
speed_right  in  10  signed target speed, right wheel
uart_tx  out  1  serial output; idles high
busy  out  1  high while a frame is in flight
frame_done  out  1  one-cycle pulse at the end of each frame
dropped_count  out  8  saturating count of rejected triggers

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- Reset values: uart_tx=1, busy=0, frame_done=0, dropped_count=0, seq=0, period timer=0, FSM=IDLE.
- Reset mid-frame: on the next edge the frame is aborted and uart_tx returns high. No partial byte resumes afterwards.
- Period timer:
  - Counts only while enable=1 and wraps at PERIOD_CYCLES-1.
  - The wrap cycle produces an internal tick.
  - enable=0 clears the timer to 0 on the next edge.
- Trigger: trigger = tick OR send.
  - Sampled in IDLE at edge T: the inputs are latched into a snapshot register at that edge, and seq is captured.
  - At the same edge: seq increments (mod 256), busy goes to 1, FSM goes to START.
  - uart_tx goes low in cycle T+1.
- Trigger while busy: ignored. dropped_count increments and saturates at 255.
  - The frame_done cycle counts as busy for this purpose.
  - A simultaneous tick and send counts as one trigger.
- Packet bytes, transmitted in order:
  - b0 = 0xA5 (sync)
  - b1 = seq
  - b2 = pitch[7:0]
  - b3 = yaw[7:0]
  - b4 = speed_left[7:0]
  - b5 = speed_right[7:0]
  - b6 = {2'b00, speed_right[9:8], speed_left[9:8], yaw[8], pitch[8]}
  - The optional checksum byte follows b6 (see Optional Feature).
- UART bit timing: 8N1, LSB first, each bit held exactly CLKS_PER_BIT cycles. Bytes are sent back-to-back with no idle gap.
- FSM: IDLE -> START (1 bit) -> DATA (8 bits, bit index 0..7) -> STOP (1 bit).
  - Leaving STOP: go to START if the byte index is below the last, otherwise to IDLE.
- Frame end: in the cycle after the last stop bit's final cycle, busy=0 and frame_done=1 for one cycle. A new trigger is accepted from the following cycle.
- Frame length: N_BYTES*10*CLKS_PER_BIT cycles, from the first low cycle to the frame_done cycle exclusive.
- Input changes during a frame do not affect it; only the snapshot is transmitted.
- Counters: bit counter width is clog2(CLKS_PER_BIT). Period timer width is clog2(PERIOD_CYCLES).

Optional Feature:
TELEM_CHECKSUM_EN
- Defined: b7 = XOR of b1..b6 is appended, so N_BYTES=8.
- Undefined: frame ends after b6, N_BYTES=7, and no checksum logic is synthesised.

Test Plan:
- Common bench setting: CLKS_PER_BIT=4, PERIOD_CYCLES=1000.
- Basic frame: enable=0; pitch=9'h1FD (-3), yaw=9'h05A, speed_left=10'h155, speed_right=10'h2AA; pulse send.
  -> Decoded bytes A5 00 FD 5A 55 AA 25, then 7D with TELEM_CHECKSUM_EN.
  -> Frame is 320 cycles (280 without the macro); frame_done is a single pulse; busy is high throughout.
- Periodic: enable=1 for 3500 cycles, no send.
  -> Exactly 3 frames, each starting 1 cycle after a timer wrap.
  -> seq values 0, 1, 2.
- Drop: pulse send, then pulse send again 50 cycles later and again in the frame_done cycle.
  -> One frame only; dropped_count=2.
  -> Saturation: 300 rejected triggers -> dropped_count=255.
- Snapshot coherence: change pitch to 9'h010 mid-frame, during b1.
  -> b2 still 0xFD; the next frame carries 0x10.
- Reset mid-frame: assert reset during the DATA state of b3.
  -> uart_tx=1 on the next edge; busy=0.
  -> The next send produces a full frame with seq=0.
- Bit timing: measure every bit width and the start-bit position relative to the send edge.
  -> Each bit exactly 4 cycles; first low cycle is T+1.
